// File: rtl/bloom_pkg.sv
// Shared types and default sizes for the Bloom-filter rule controller.
//   state_t : controller FSM states
//   op_t    : operation type latched at request acceptance
//   hkey_t  : tuple fields actually presented to the hash engine
package bloom_pkg;

  localparam int FILTER_BITS_DEF  = 1024;
  localparam int IDX_W_DEF        = 10;
  localparam int CLR_W_DEF        = 64;
  localparam int HASH_TIMEOUT_DEF = 31;

  typedef enum logic [2:0] {IDLE, START, WAIT, APPLY, CLEAR} state_t;
  typedef enum logic {LOOKUP, INSERT} op_t;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] src;
    logic [15:0] dst;
  } hkey_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bloom_if.sv
// Request/result/hash-engine bundle for bloom_ctrl.
//   slave  : the controller side (bloom_ctrl)
//   master : requester plus external hash engine side
interface bloom_if;
  logic        lkp_valid, lkp_ready;
  logic [71:0] lkp_ip;
  logic [15:0] lkp_src, lkp_dst;
  logic        ins_valid, ins_ready;
  logic [71:0] ins_ip;
  logic [15:0] ins_src, ins_dst;
  logic        clr_req, clr_busy;
  logic        res_valid, res_hit, res_err;
  logic        ins_done, ins_err;
  logic [15:0] hit_cnt;
  logic        hs_start;
  logic [31:0] hs_k0;
  logic [15:0] hs_k1, hs_k2;
  logic [31:0] hs_key;
  logic        hs_valid;

  modport slave (
    input  lkp_valid, lkp_ip, lkp_src, lkp_dst,
    input  ins_valid, ins_ip, ins_src, ins_dst,
    input  clr_req, hs_key, hs_valid,
    output lkp_ready, ins_ready, clr_busy,
    output res_valid, res_hit, res_err, ins_done, ins_err, hit_cnt,
    output hs_start, hs_k0, hs_k1, hs_k2
  );

  modport master (
    output lkp_valid, lkp_ip, lkp_src, lkp_dst,
    output ins_valid, ins_ip, ins_src, ins_dst,
    output clr_req, hs_key, hs_valid,
    input  lkp_ready, ins_ready, clr_busy,
    input  res_valid, res_hit, res_err, ins_done, ins_err, hit_cnt,
    input  hs_start, hs_k0, hs_k1, hs_k2
  );
endinterface

// File: rtl/bloom_rr_arb.sv
// Two-way round-robin arbiter, lookup (req[0]) vs insert (req[1]).
//   clk, reset : clock, synchronous active-high reset
//   i_en       : grants allowed this cycle
//   i_req      : {insert, lookup} requests
//   o_gnt      : one-hot grant, doubles as ready; a grant is an acceptance
module bloom_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // High when insert wins the next tie; reset favours lookup.
  logic r_prio_ins;

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (i_req[0] && (!i_req[1] || !r_prio_ins)) o_gnt[0] = 1'b1;
      else if (i_req[1])                          o_gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         r_prio_ins <= 1'b0;
    else if (o_gnt[0]) r_prio_ins <= 1'b1;
    else if (o_gnt[1]) r_prio_ins <= 1'b0;
  end

endmodule

// File: rtl/bloom_ctrl.sv
// Bloom-filter rule controller: serialises lookups and inserts through an
// external hash engine, owns the filter bit array and a chunked clear.
//   clk, reset : clock, synchronous active-high reset
//   bus        : bloom_if.slave -- lookup/insert handshakes, clear request,
//                result/done pulses, hit counter, hash engine start/keys/result
module bloom_ctrl
  import bloom_pkg::*;
#(
  parameter int FILTER_BITS  = FILTER_BITS_DEF,
  parameter int IDX_W        = IDX_W_DEF,
  parameter int CLR_W        = CLR_W_DEF,
  parameter int HASH_TIMEOUT = HASH_TIMEOUT_DEF
) (
  input  logic    clk,
  input  logic    reset,
  bloom_if.slave  bus
);

  localparam int NCHUNK = FILTER_BITS / CLR_W;
  localparam int CCW    = cnt_w(NCHUNK);
  localparam int TOW    = cnt_w(HASH_TIMEOUT + 1);

  state_t                 r_state, w_nxt;
  op_t                    r_op;
  hkey_t                  r_key;
  logic [IDX_W-1:0]       r_idx;
  logic [TOW-1:0]         r_to_cnt;
  logic [CCW-1:0]         r_clr_cnt;
  logic                   r_clr_pend;
  logic [FILTER_BITS-1:0] r_filter;
  logic [15:0]            r_hit_cnt;
  logic                   r_res_valid, r_res_hit, r_res_err, r_ins_done, r_ins_err;

  logic [1:0] w_gnt;
  logic       w_en, w_acc, w_timeout, w_clr_last, w_lkp_hit;

  // A same-cycle clr_req blocks grants so the clear wins over waiting requests.
  assign w_en       = (r_state == IDLE) && !r_clr_pend && !bus.clr_req;
  assign w_acc      = |w_gnt;
  assign w_timeout  = (r_state == WAIT) && !bus.hs_valid &&
                      (r_to_cnt == TOW'(HASH_TIMEOUT - 1));
  assign w_clr_last = (r_clr_cnt == CCW'(NCHUNK - 1));
  assign w_lkp_hit  = r_filter[r_idx];

  bloom_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_en),
    .i_req ({bus.ins_valid, bus.lkp_valid}),
    .o_gnt (w_gnt)
  );

  assign bus.lkp_ready = w_gnt[0];
  assign bus.ins_ready = w_gnt[1];
  assign bus.clr_busy  = r_clr_pend || (r_state == CLEAR);
  assign bus.hs_start  = (r_state == START);
  assign bus.hs_k0     = r_key.ip;
  assign bus.hs_k1     = r_key.src;
  assign bus.hs_k2     = r_key.dst;
  assign bus.res_valid = r_res_valid;
  assign bus.res_hit   = r_res_hit;
  assign bus.res_err   = r_res_err;
  assign bus.ins_done  = r_ins_done;
  assign bus.ins_err   = r_ins_err;
  assign bus.hit_cnt   = r_hit_cnt;

  // Only ip[31:0] reaches the hash, only the low key bits index the filter.
  logic w_unused_bits;
  assign w_unused_bits = ^{bus.lkp_ip[71:32], bus.ins_ip[71:32], bus.hs_key[31:IDX_W]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.clr_req || r_clr_pend) w_nxt = CLEAR;
               else if (w_acc)                w_nxt = START;
      START:   w_nxt = WAIT;
      WAIT:    if (bus.hs_valid)   w_nxt = APPLY;
               else if (w_timeout) w_nxt = IDLE;
      APPLY:   w_nxt = IDLE;
      CLEAR:   if (w_clr_last) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= LOOKUP;
      r_key       <= '0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_clr_cnt   <= '0;
      r_clr_pend  <= 1'b0;
      r_filter    <= '0;
      r_hit_cnt   <= '0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_err   <= 1'b0;
      r_ins_done  <= 1'b0;
      r_ins_err   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_err   <= 1'b0;
      r_ins_done  <= 1'b0;
      r_ins_err   <= 1'b0;

      if (w_acc) begin
        r_op  <= w_gnt[1] ? INSERT : LOOKUP;
        r_key <= w_gnt[1] ? '{ip: bus.ins_ip[31:0], src: bus.ins_src, dst: bus.ins_dst}
                          : '{ip: bus.lkp_ip[31:0], src: bus.lkp_src, dst: bus.lkp_dst};
      end

      r_to_cnt <= (r_state == WAIT) ? r_to_cnt + 1'b1 : '0;
      if (r_state == WAIT && bus.hs_valid) r_idx <= bus.hs_key[IDX_W-1:0];

      // Request arriving mid-operation is remembered and served from IDLE.
      if (r_state == IDLE)
        r_clr_pend <= 1'b0;
      else if (bus.clr_req && r_state != CLEAR)
        r_clr_pend <= 1'b1;

      if (r_state == APPLY) begin
        if (r_op == LOOKUP) begin
          r_res_valid <= 1'b1;
          r_res_hit   <= w_lkp_hit;
          if (w_lkp_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
        end else begin
          r_filter[r_idx] <= 1'b1;
          r_ins_done      <= 1'b1;
        end
      end

      if (w_timeout) begin
        if (r_op == LOOKUP) begin
          r_res_valid <= 1'b1;
          r_res_err   <= 1'b1;
        end else begin
          r_ins_done <= 1'b1;
          r_ins_err  <= 1'b1;
        end
      end

      if (r_state == CLEAR) begin
        r_filter[int'(r_clr_cnt)*CLR_W +: CLR_W] <= '0;
        r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bloom_ctrl.sv
module tb_bloom_ctrl;
  import bloom_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bloom_if bus();

  bloom_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          ins;
    bit          hit;
    bit          err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  bit          mdl[1024];
  logic [15:0] mdl_cnt = 0;
  bit          hs_en = 1'b1;
  logic [31:0] e_k0 = 0;
  logic [15:0] e_k1 = 0, e_k2 = 0;
  int          acc_cyc = 0, pulse_cyc = 0;
  bit          prev_start = 1'b0;
  logic [31:0] pool[8] = '{32'h5, 32'h405, 32'hABC00005, 32'h6,
                           32'h3FF, 32'h12345678, 32'h0, 32'h7FF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic mdl_clear();
    foreach (mdl[i]) mdl[i] = 1'b0;
  endtask

  // Reference: idx = low 10 bits of ip[31:0] ^ {src,dst}; a lookup hits when the bit
  // is set; a failed hash yields an error with no state change.
  task automatic accept_push(input bit ins, input logic [71:0] ip,
                             input logic [15:0] s, input logic [15:0] d, input bit push);
    logic [31:0] h;
    int          idx;
    exp_t        e;
    h       = ip[31:0] ^ {s, d};
    idx     = int'(h[9:0]);
    e_k0    = ip[31:0];
    e_k1    = s;
    e_k2    = d;
    acc_cyc = cyc;
    if (push) begin
      e.ins = ins;
      e.err = !hs_en;
      e.hit = 1'b0;
      if (ins) begin
        if (hs_en) mdl[idx] = 1'b1;
      end else if (hs_en && mdl[idx]) begin
        e.hit = 1'b1;
        if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
      end
      e.cnt = mdl_cnt;
      q.push_back(e);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.res_valid || bus.ins_done)) begin
      pulse_cyc = cyc;
      chk("single_pulse", 32'(bus.res_valid & bus.ins_done), 32'd0);
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pulse: res_valid=%0b ins_done=%0b with nothing outstanding (cycle %0d)",
                 bus.res_valid, bus.ins_done, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_ins", 32'(bus.ins_done), 32'(e.ins));
        if (e.ins) chk("ins_err", 32'(bus.ins_err), 32'(e.err));
        else begin
          chk("res_hit", 32'(bus.res_hit), 32'(e.hit));
          chk("res_err", 32'(bus.res_err), 32'(e.err));
        end
        chk("hit_cnt", 32'(bus.hit_cnt), 32'(e.cnt));
      end
    end
  end

  // Hash engine model: key = k0 ^ {k1,k2}, valid three cycles after hs_start.
  always @(negedge clk) begin
    if (reset) prev_start = 1'b0;
    else begin
      if (bus.hs_start) begin
        chk("hs_start_one_cycle", 32'(prev_start), 32'd0);
        chk("hs_k0", bus.hs_k0, e_k0);
        chk("hs_k1", 32'(bus.hs_k1), 32'(e_k1));
        chk("hs_k2", 32'(bus.hs_k2), 32'(e_k2));
        if (hs_en) begin
          fork
            begin
              automatic logic [31:0] kk = bus.hs_k0 ^ {bus.hs_k1, bus.hs_k2};
              repeat (3) @(posedge clk);
              #1;
              bus.hs_key   = kk;
              bus.hs_valid = 1'b1;
              @(posedge clk);
              #1;
              bus.hs_valid = 1'b0;
            end
          join_none
        end
      end
      prev_start = bus.hs_start;
    end
  end

  task automatic do_op(input bit ins, input logic [71:0] ip,
                       input logic [15:0] s, input logic [15:0] d, input bit push);
    int n = 0;
    @(negedge clk);
    if (ins) begin
      bus.ins_valid = 1'b1; bus.ins_ip = ip; bus.ins_src = s; bus.ins_dst = d;
    end else begin
      bus.lkp_valid = 1'b1; bus.lkp_ip = ip; bus.lkp_src = s; bus.lkp_dst = d;
    end
    #1;
    while (!(ins ? bus.ins_ready : bus.lkp_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) bound_fail("accept");
    else          accept_push(ins, ip, s, d, push);
    @(posedge clk); #1;
    bus.lkp_valid = 1'b0;
    bus.ins_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin bound_fail("drain"); q.delete(); end
    @(negedge clk);
  endtask

  task automatic wait_clr_done();
    int n = 0;
    #1;
    while (bus.clr_busy && n < 100) begin @(negedge clk); #1; n++; end
    if (bus.clr_busy) bound_fail("clr_done");
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mdl_clear(); mdl_cnt = 0; q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         n, bad;
    bit         got[3];
    bit         ins;
    logic [71:0] ip;
    logic [15:0] s, d;

    bus.lkp_valid = 0; bus.lkp_ip = 0; bus.lkp_src = 0; bus.lkp_dst = 0;
    bus.ins_valid = 0; bus.ins_ip = 0; bus.ins_src = 0; bus.ins_dst = 0;
    bus.clr_req = 0; bus.hs_key = 0; bus.hs_valid = 0;
    mdl_clear();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hit_cnt",   32'(bus.hit_cnt),   32'd0);
    chk("rst_clr_busy",  32'(bus.clr_busy),  32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_ins_done",  32'(bus.ins_done),  32'd0);
    chk("rst_hs_start",  32'(bus.hs_start),  32'd0);
    reset = 1'b0;

    // Insert then lookup of the same tuple; aliasing through the low index bits.
    do_op(1, 72'h5, 16'h0, 16'h0, 1); drain();
    chk("ins_latency", 32'(pulse_cyc - acc_cyc), 32'd6);
    do_op(0, 72'h5, 16'h0, 16'h0, 1); drain();
    chk("lkp_latency", 32'(pulse_cyc - acc_cyc), 32'd6);
    do_op(0, 72'h6, 16'h0, 16'h0, 1); drain();
    do_op(0, 72'h405, 16'h0, 16'h0, 1); drain();

    // Both requests held from reset: grants go lookup, insert, lookup.
    do_reset();
    @(negedge clk);
    bus.lkp_valid = 1; bus.lkp_ip = 72'h77; bus.lkp_src = 16'h1; bus.lkp_dst = 16'h2;
    bus.ins_valid = 1; bus.ins_ip = 72'h77; bus.ins_src = 16'h1; bus.ins_dst = 16'h2;
    #1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!(bus.lkp_ready || bus.ins_ready) && n < 200) begin @(negedge clk); #1; n++; end
      if (n >= 200) bound_fail("rr_accept");
      else begin
        got[g] = bus.ins_ready;
        accept_push(got[g], 72'h77, 16'h1, 16'h2, 1);
      end
      @(posedge clk); #1;
      if (g == 2) begin bus.lkp_valid = 0; bus.ins_valid = 0; end
    end
    chk("rr_grant0_ins", 32'(got[0]), 32'd0);
    chk("rr_grant1_ins", 32'(got[1]), 32'd1);
    chk("rr_grant2_ins", 32'(got[2]), 32'd0);
    drain();

    // Clear requested while a lookup waits on the hash.
    do_op(1, 72'h99, 16'h0, 16'h0, 1); drain();
    do_op(0, 72'h99, 16'h0, 16'h0, 1);
    @(negedge clk);
    @(negedge clk); bus.clr_req = 1'b1;
    @(negedge clk); bus.clr_req = 1'b0;
    mdl_clear();
    n = 0;
    while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.res_valid) bound_fail("clr_wait_result");
    chk("clr_busy_at_result", 32'(bus.clr_busy), 32'd1);
    n = 0;
    while (bus.clr_busy && n < 100) begin n++; @(negedge clk); end
    chk("clr_pend_len_ok", 32'(n >= 16 && n <= 17), 32'd1);
    do_op(0, 72'h99, 16'h0, 16'h0, 1); drain();

    // Clear from IDLE wins over a waiting lookup and lasts 16 cycles.
    do_op(1, 72'h99, 16'h0, 16'h0, 1); drain();
    @(negedge clk);
    bus.clr_req = 1'b1;
    bus.lkp_valid = 1'b1; bus.lkp_ip = 72'h99; bus.lkp_src = 0; bus.lkp_dst = 0;
    #1;
    chk("ready_with_clr_req", 32'(bus.lkp_ready), 32'd0);
    @(negedge clk); bus.clr_req = 1'b0;
    mdl_clear();
    #1;
    n = 0; bad = 0;
    while (bus.clr_busy && n < 100) begin
      if (bus.lkp_ready) bad++;
      n++;
      @(negedge clk); #1;
    end
    bus.lkp_valid = 1'b0;
    chk("clr_idle_len", 32'(n), 32'd16);
    chk("ready_in_clear", 32'(bad), 32'd0);
    do_op(0, 72'h99, 16'h0, 16'h0, 1); drain();

    // Hash never answers: error result, then normal service resumes.
    do_op(1, 72'h55, 16'h0, 16'h0, 1); drain();
    hs_en = 1'b0;
    do_op(0, 72'h55, 16'h0, 16'h0, 1); drain();
    chk("timeout_latency", 32'(pulse_cyc - acc_cyc), 32'd33);
    do_op(1, 72'h66, 16'h0, 16'h0, 1); drain();
    hs_en = 1'b1;
    do_op(0, 72'h55, 16'h0, 16'h0, 1); drain();
    do_op(0, 72'h66, 16'h0, 16'h0, 1); drain();

    // Reset during WAIT: no result, filter and counter wiped, late hash ignored.
    do_op(1, 72'h1234, 16'h3, 16'h4, 1); drain();
    do_op(0, 72'h1234, 16'h3, 16'h4, 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    mdl_clear(); mdl_cnt = 0;
    repeat (8) @(negedge clk);
    chk("post_rst_hit_cnt",  32'(bus.hit_cnt),  32'd0);
    chk("post_rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    do_op(0, 72'h1234, 16'h3, 16'h4, 1); drain();

    // Randomised traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        @(negedge clk); bus.clr_req = 1'b1;
        @(negedge clk); bus.clr_req = 1'b0;
        mdl_clear();
        wait_clr_done();
      end else begin
        hs_en = ($urandom_range(0, 9) != 0);
        ins   = 1'($urandom_range(0, 1));
        ip    = {8'($urandom), 32'($urandom), pool[$urandom_range(0, 7)]};
        s     = 16'($urandom_range(0, 3));
        d     = 16'($urandom_range(0, 3));
        do_op(ins, ip, s, d, 1);
        drain();
        hs_en = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bloom_ctrl.md
BLOOM_CTRL -- requirements
Module: bloom_ctrl

Interface
REQ-001 The block SHALL have parameters (one per line: name, default, meaning):
  FILTER_BITS, 1024, Bloom filter size in bits
  IDX_W, 10, filter index width (log2 FILTER_BITS)
  CLR_W, 64, bits zeroed per clear cycle
  HASH_TIMEOUT, 31, max cycles waiting for hs_valid
REQ-002 The block SHALL have ports (name direction width meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high reset
  lkp_valid/lkp_ready  in/out  1/1  lookup request handshake
  lkp_ip, lkp_src, lkp_dst  in  72/16/16  lookup tuple
  ins_valid/ins_ready  in/out  1/1  rule-insert request handshake
  ins_ip, ins_src, ins_dst  in  72/16/16  insert tuple
  clr_req  in  1  clear-filter request pulse
  clr_busy  out  1  clear in progress or pending
  res_valid, res_hit, res_err  out  1/1/1  lookup result pulse, hit flag, timeout flag
  ins_done, ins_err  out  1/1  insert completion pulse, timeout flag
  hit_cnt  out  16  saturating lookup-hit counter
  hs_start  out  1  hash engine start pulse
  hs_k0, hs_k1, hs_k2  out  32/16/16  hash keys (ip[31:0], src, dst)
  hs_key, hs_valid  in  32/1  hash result and valid pulse
REQ-003 Clock port SHALL be clk; reset port SHALL be reset, synchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, START, WAIT, APPLY, CLEAR.
REQ-005 lkp_ready/ins_ready SHALL be combinational: high only in IDLE, no clear pending, and granted by arbiter.
REQ-006 Both valid in IDLE: grant the one not granted last (round-robin); single valid: grant it.
REQ-007 On acceptance (valid&&ready) at cycle T: tuple and op type registered, state START at T+1.
REQ-008 START SHALL assert hs_start for exactly one cycle, then go to WAIT.
REQ-009 hs_k0/k1/k2 SHALL hold registered tuple stable from START until leaving WAIT.
REQ-010 WAIT: on hs_valid capture hs_key[IDX_W-1:0] as index, go to APPLY; upper key bits ignored.
REQ-011 APPLY lookup: res_valid=1 one cycle, res_hit=filter[index], res_err=0; hit_cnt+1 on hit, saturating at 16'hFFFF.
REQ-012 APPLY insert: set filter[index]=1, ins_done=1 one cycle, ins_err=0; APPLY always returns to IDLE.
REQ-013 WAIT timeout: HASH_TIMEOUT cycles without hs_valid -> IDLE; lookup pulses res_valid with res_err=1,res_hit=0; insert pulses ins_done with ins_err=1, filter unchanged.
REQ-014 clr_req in IDLE enters CLEAR next cycle, taking priority over pending lookup/insert.
REQ-015 clr_req while busy SHALL latch a pending flag; CLEAR entered on return to IDLE; clr_req during CLEAR ignored.
REQ-016 CLEAR SHALL zero CLR_W bits per cycle via wrapping counter, FILTER_BITS/CLR_W cycles (16 default), then IDLE.
REQ-017 clr_busy SHALL be high while pending or in CLEAR.
REQ-018 hit_cnt SHALL not be cleared by CLEAR.

Reset
REQ-019 reset SHALL force IDLE, filter all zero, hit_cnt=0, pending clear=0, round-robin pointer favouring lookup, all pulse outputs 0, hs_start=0.
REQ-020 reset mid-operation SHALL abandon the operation with no result/done pulse; late hs_valid in IDLE ignored.

Structure
REQ-021 Package bloom_pkg SHALL hold the state typedef, FILTER_BITS/IDX_W/CLR_W defaults and op-type enum (LOOKUP, INSERT).
REQ-022 Hash engine external, connected via hs_* ports; one sub-module bloom_rr_arb (2-way round-robin) natural.

Verification (hash model: hs_key=hs_k0^{hs_k1,hs_k2}, hs_valid 3 cycles after hs_start)
REQ-023 Insert ip[31:0]=5,src=0,dst=0 -> ins_done 6 cycles after acceptance; lookup same -> res_hit=1, hit_cnt=1.
REQ-024 Lookup ip=6 after REQ-023 -> res_hit=0; lookup ip=0x405 -> res_hit=1 (index alias 5).
REQ-025 lkp_valid and ins_valid held together from reset -> grants alternate lookup, insert, lookup.
REQ-026 clr_req during WAIT -> op completes, clr_busy high, 16 CLEAR cycles, then lookup ip=5 -> res_hit=0, hit_cnt retained.
REQ-027 Model never asserts hs_valid -> res_valid with res_err=1 after 31 WAIT cycles; next lookup accepted.
REQ-028 reset asserted in WAIT -> no res_valid, lookup of previously inserted key -> res_hit=0.
